vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 79 +++++++
 tb/tb_vram_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: fixed-priority scanout/write arbiter in front of a single-port frame-buffer SRAM.
// Define VRAM_ARB_STALL_STATS_EN to add the stall_cnt/stall_clr writer-stall statistics.
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_valid,
  output logic [DATA_W-1:0] sc_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef VRAM_ARB_STALL_STATS_EN
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt,
`endif
  output logic              wr_idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  logic full, empty, push, pop, req_d;
  logic [1:0] state_nx;
  // extra pointer MSB distinguishes full from empty when the low bits match
  assign full     = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty    = wp == rp;
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign state_nx = sc_req ? S_SCAN : !empty ? S_WRITE : S_IDLE;
  assign pop      = state_nx == S_WRITE;
  assign wr_idle  = empty && !mem_we;
  assign sc_data  = mem_rdata;
  always_ff @(posedge Clk)
    if (push) begin
      q_addr[wp[PW-1:0]] <= wr_addr;
      q_data[wp[PW-1:0]] <= wr_data;
    end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      wp        <= '0;
      rp        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_d     <= 1'b0;
      sc_valid  <= 1'b0;
    end else begin
      wp       <= wp + {{PW{1'b0}}, push};
      rp       <= rp + {{PW{1'b0}}, pop};
      mem_we   <= pop;
      req_d    <= sc_req;
      sc_valid <= req_d;
      if (state_nx == S_SCAN) mem_addr <= sc_addr;
      else if (pop) begin
        mem_addr  <= q_addr[rp[PW-1:0]];
        mem_wdata <= q_data[rp[PW-1:0]];
      end
    end
`ifdef VRAM_ARB_STALL_STATS_EN
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) stall_cnt <= '0;
    else if (stall_clr) stall_cnt <= '0;
    else if (sc_req && !empty && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized scoreboard bench for vram_arbiter against a queue-based reference model.
// Define VRAM_ARB_STALL_STATS_EN to also exercise the stall counter.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW = 19, DW = 6, D = 4;
  logic Clk = 0, Reset_n = 1;
  logic sc_req = 0, sc_valid, wr_valid = 0, wr_ready, mem_we, wr_idle;
  logic [AW-1:0] sc_addr = '0, wr_addr = '0, mem_addr;
  logic [DW-1:0] sc_data, wr_data = '0, mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STALL_STATS_EN
  logic stall_clr = 0;
  logic [15:0] stall_cnt;
`endif
  always #10 Clk = ~Clk;
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .sc_req(sc_req), .sc_addr(sc_addr), .sc_valid(sc_valid),
    .sc_data(sc_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef VRAM_ARB_STALL_STATS_EN
    .stall_clr(stall_clr), .stall_cnt(stall_cnt),
`endif
    .wr_idle(wr_idle));
  // synchronous SRAM: read data appears one cycle after the address edge
  logic [DW-1:0] sram [1<<AW];
  always @(posedge Clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int c; logic [AW-1:0] a; } sc_t;
  wr_t wq[$], issued[$], w;
  sc_t scq[$], s;
  logic [DW-1:0] ref_mem [int];
  int cyc = 0, n_vec = 0, n_err = 0;
  int unsigned exp_stall = 0;
  bit exp_we = 0, exp_ready = 1, exp_idle = 1, m_full, due, wr_on = 0, acc = 0;
  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return a == 19'h12C0 ? 6'h2A : a[5:0] ^ a[12:7];
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  // reference model: write queue, issued-write scoreboard, scanout request scoreboard
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wq.delete(); issued.delete(); scq.delete();
      exp_we = 0; exp_ready = 1; exp_idle = 1; exp_stall = 0;
    end else begin
      cyc++;
      m_full = wq.size() == D;
`ifdef VRAM_ARB_STALL_STATS_EN
      if (stall_clr) exp_stall = 0;
      else if (sc_req && wq.size() > 0 && exp_stall < 65535) exp_stall++;
`endif
      if (sc_req) scq.push_back('{cyc, sc_addr});
      exp_we = !sc_req && wq.size() > 0;
      if (exp_we) begin
        issued.push_back(wq[0]);
        ref_mem[int'(wq[0].a)] = wq[0].d;
        void'(wq.pop_front());
      end
      if (wr_valid && !m_full) wq.push_back('{wr_addr, wr_data});
      exp_ready = wq.size() < D;
      exp_idle = wq.size() == 0 && !exp_we;
    end
  end
  // monitor
  always @(posedge Clk) begin
    #1;
    if (Reset_n) begin
      chk("mem_we", mem_we, exp_we);
      if (exp_we) begin
        w = issued.pop_front();
        if (mem_we) begin
          chk("mem_addr", mem_addr, w.a);
          chk("mem_wdata", mem_wdata, w.d);
        end
      end
      chk("wr_ready", wr_ready, exp_ready);
      chk("wr_idle", wr_idle, exp_idle);
      due = scq.size() > 0 && scq[0].c + 1 == cyc;
      chk("sc_valid", sc_valid, due);
      if (due) begin
        s = scq.pop_front();
        if (sc_valid) chk("sc_data", sc_data, f(s.a));
      end
`ifdef VRAM_ARB_STALL_STATS_EN
      chk("stall_cnt", stall_cnt, exp_stall);
`endif
    end
  end
  // writer: holds each offer until accepted
  always @(posedge Clk) acc = wr_valid && wr_ready;
  always @(negedge Clk)
    if (!wr_valid || acc) begin
      wr_valid = wr_on;
      wr_addr = {1'b1, 18'($urandom)};
      wr_data = 6'($urandom);
    end
  task automatic tick(input bit req);
    @(negedge Clk);
    sc_req = req;
    sc_addr = {1'b0, 18'($urandom)};
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = f(AW'(i));
    #1 Reset_n = 0;
    repeat (2) @(negedge Clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_sc_valid", sc_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_wr_idle", wr_idle, 1);
    Reset_n = 1;
    @(negedge Clk);
    sc_req = 1;
    sc_addr = 19'h12C0;
    repeat (4) tick(0);
    wr_on = 1;
    repeat (8) tick(1);
    repeat (12) tick(0);
    wr_on = 0;
    repeat (6) tick(0);
    wr_on = 1;
    for (int i = 0; i < 40; i++) tick(i[0]);
    wr_on = 0;
    repeat (8) tick(0);
    for (int i = 0; i < 30; i++) begin
      wr_on = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 400; i++) begin
      wr_on = $urandom_range(0, 3) != 0;
      tick($urandom_range(0, 1) == 1);
    end
    wr_on = 0;
    repeat (12) tick(0);
    wr_on = 1;
    for (int k = 0; k < 20 && wq.size() < 3; k++) tick(1);
    wr_on = 0;
    chk("pre_rst_wr_idle", wr_idle, 0);
    Reset_n = 0;
    #1;
    chk("rst_q_mem_we", mem_we, 0);
    chk("rst_q_wr_ready", wr_ready, 1);
    chk("rst_q_wr_idle", wr_idle, 1);
    chk("rst_q_sc_valid", sc_valid, 0);
    sc_req = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    repeat (10) tick(0);
`ifdef VRAM_ARB_STALL_STATS_EN
    wr_on = 1;
    for (int k = 0; k < 20 && wq.size() < D; k++) tick(1);
    stall_clr = 1;
    @(negedge Clk);
    stall_clr = 0;
    repeat (20) @(negedge Clk);
    chk("stall_20", stall_cnt, 20);
    stall_clr = 1;
    @(negedge Clk);
    stall_clr = 0;
    chk("stall_clr", stall_cnt, 0);
    repeat (65540) @(negedge Clk);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    wr_on = 0;
    repeat (12) tick(0);
`endif
    foreach (ref_mem[k]) chk("sram_content", sram[k], ref_mem[k]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
